// File: rtl/prog_loader.sv
// prog_loader: parses framed UART byte streams into word writes to one of
// several RAM banks, checks an 8-bit frame checksum and holds the core in
// reset until a boot command arrives.
module prog_loader #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_dv_i,
  input  logic [7:0]           rx_byte_i,
  output logic                 we_o,
  output logic [NUM_BANKS-1:0] bank_o,
  output logic [ADDR_W-1:0]    addr_o,
  output logic [DATA_W-1:0]    wdata_o,
  output logic                 core_rst_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] HDR      = 8'hA5;
  localparam logic [7:0] CMD_BOOT = 8'hB0;
  localparam logic [7:0] CMD_HALT = 8'hC0;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CMD  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [3:0] {
    StIdle, StCmd, StAddr0, StAddr1, StCnt0, StCnt1, StData, StCsum, StBooted
  } state_e;

  state_e                r_state;
  logic                  r_boot_hdr;   // header seen while booted, next byte is a command
  logic [7:0]            r_sum;
  logic [3:0]            r_bank;
  logic [15:0]           r_addr;       // full 16 bits kept, output truncates to ADDR_W
  logic [15:0]           r_cnt;
  logic [3:0]            r_bidx;
  logic [DATA_W-1:0]     r_word;
  logic [TMO_W-1:0]      r_tmo;
  logic                  r_we;
  logic [NUM_BANKS-1:0]  r_bank_oh;
  logic [ADDR_W-1:0]     r_addr_out;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_core_rst;
  logic                  r_err;
  logic [1:0]            r_err_code;

  logic                  w_in_frame;
  logic                  w_tmo_hit;
  logic                  w_is_wr_cmd;
  logic                  w_last_byte;
  logic [7:0]            w_sum_next;
  logic [DATA_W-1:0]     w_word;
  logic [NUM_BANKS-1:0]  w_bank_oh;

  assign w_in_frame  = (r_state != StIdle) && (r_state != StBooted);
  assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
  assign w_is_wr_cmd = ({24'd0, rx_byte_i} < NUM_BANKS);
  assign w_last_byte = (r_bidx == 4'(NBYTES - 1));
  assign w_sum_next  = r_sum + rx_byte_i;

  // Merge the incoming payload byte into its little-endian lane of the word.
  always_comb begin
    w_word = r_word;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (r_bidx == i[3:0]) w_word[8*i +: 8] = rx_byte_i;
    end
  end

  // Decode the latched bank index to a one-hot select.
  always_comb begin
    w_bank_oh = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      w_bank_oh[b] = (r_bank == b[3:0]);
    end
  end

  // Frame parser FSM with registered write port, error and core-reset outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_boot_hdr <= 1'b0;
      r_sum      <= '0;
      r_bank     <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_bidx     <= '0;
      r_word     <= '0;
      r_tmo      <= '0;
      r_we       <= 1'b0;
      r_bank_oh  <= '0;
      r_addr_out <= '0;
      r_wdata    <= '0;
      r_core_rst <= 1'b1;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_we <= 1'b0;
      if (w_in_frame && !rx_dv_i) r_tmo <= r_tmo + 1'b1;
      else                        r_tmo <= '0;

      // A byte arriving on the expiry cycle wins over the timeout.
      if (w_in_frame && !rx_dv_i && w_tmo_hit) begin
        r_err      <= 1'b1;
        r_err_code <= ERR_TMO;
        r_state    <= StIdle;
      end else if (rx_dv_i) begin
        case (r_state)
          StIdle: begin
            if (rx_byte_i == HDR) begin
              r_state    <= StCmd;
              r_sum      <= '0;
              r_err      <= 1'b0;
              r_err_code <= ERR_NONE;
            end
          end
          StCmd: begin
            r_sum <= w_sum_next;
            if (w_is_wr_cmd) begin
              r_bank  <= rx_byte_i[3:0];
              r_state <= StAddr0;
            end else if (rx_byte_i == CMD_BOOT) begin
              r_core_rst <= 1'b0;
              r_boot_hdr <= 1'b0;
              r_state    <= StBooted;
            end else if (rx_byte_i == CMD_HALT) begin
              r_core_rst <= 1'b1;
              r_state    <= StIdle;
            end else begin
              r_err      <= 1'b1;
              r_err_code <= ERR_CMD;
              r_state    <= StIdle;
            end
          end
          StAddr0: begin
            r_sum       <= w_sum_next;
            r_addr[7:0] <= rx_byte_i;
            r_state     <= StAddr1;
          end
          StAddr1: begin
            r_sum        <= w_sum_next;
            r_addr[15:8] <= rx_byte_i;
            r_state      <= StCnt0;
          end
          StCnt0: begin
            r_sum      <= w_sum_next;
            r_cnt[7:0] <= rx_byte_i;
            r_state    <= StCnt1;
          end
          StCnt1: begin
            r_sum       <= w_sum_next;
            r_cnt[15:8] <= rx_byte_i;
            r_bidx      <= '0;
            r_state     <= ({rx_byte_i, r_cnt[7:0]} == 16'd0) ? StCsum : StData;
          end
          StData: begin
            r_sum  <= w_sum_next;
            r_word <= w_word;
            if (w_last_byte) begin
              r_we       <= 1'b1;
              r_bank_oh  <= w_bank_oh;
              r_addr_out <= r_addr[ADDR_W-1:0];
              r_wdata    <= w_word;
              r_addr     <= r_addr + 16'd1;
              r_cnt      <= r_cnt - 16'd1;
              r_bidx     <= '0;
              if (r_cnt == 16'd1) r_state <= StCsum;
            end else begin
              r_bidx <= r_bidx + 4'd1;
            end
          end
          StCsum: begin
            if (w_sum_next != 8'd0) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_CSUM;
            end
            r_state <= StIdle;
          end
          StBooted: begin
            // Only a halt command is honoured once the core is running.
            if (r_boot_hdr) begin
              r_boot_hdr <= 1'b0;
              if (rx_byte_i == CMD_HALT) begin
                r_core_rst <= 1'b1;
                r_state    <= StIdle;
              end
            end else if (rx_byte_i == HDR) begin
              r_boot_hdr <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign we_o       = r_we;
  assign bank_o     = r_bank_oh;
  assign addr_o     = r_addr_out;
  assign wdata_o    = r_wdata;
  assign core_rst_o = r_core_rst;
  assign busy_o     = w_in_frame;
  assign err_o      = r_err;
  assign err_code_o = r_err_code;

endmodule
